// File: rtl/score_text_render.sv
// Two-stage glyph banner renderer: region test and ROM address, then pixel lookup.
// Shadow origin/colour registers latch on frame start; optional blink by frame count.
module score_text_render #(
  parameter int width_p = 32,
  parameter int depth_p = 9
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [10:0]        pix_x_i,
  input  logic [10:0]        pix_y_i,
  input  logic               pix_valid_i,
  input  logic               frame_start_i,
  input  logic [10:0]        origin_x_i,
  input  logic [10:0]        origin_y_i,
  input  logic [11:0]        color_i,
  input  logic               blink_en_i,
  output logic [depth_p-1:0] rom_addr_o,
  input  logic [width_p-1:0] rom_data_i,
  output logic               pix_valid_o,
  output logic               pix_on_o,
  output logic [11:0]        rgb_o
);

  localparam int gw = depth_p - 6;
  localparam int cw = $clog2(width_p);
  localparam logic [31:0] wdt = 32'(width_p);
  localparam logic [31:0] span = 32'(width_p * (1 << gw));

  logic [10:0]       origin_x_q;
  logic [10:0]       origin_y_q;
  logic [11:0]       color_q;
  logic [5:0]        frame_cnt;
  logic [cw-1:0]     col_q;
  logic              in_q;
  logic              vld_q;

  logic signed [11:0] dx;
  logic signed [11:0] dy;
  logic [31:0]        ux;
  logic [31:0]        gidx;
  logic [31:0]        gcol;
  logic               in_region;
  logic               blank;
  logic               lit;
  logic [cw-1:0]      bit_idx;

  // Banner-relative offsets and the in-banner test for the incoming pixel
  always_comb begin
    dx = $signed({1'b0, pix_x_i}) - $signed({1'b0, origin_x_q});
    dy = $signed({1'b0, pix_y_i}) - $signed({1'b0, origin_y_q});
    ux = {21'b0, dx[10:0]};
    gidx = ux / wdt;
    gcol = ux % wdt;
    in_region = pix_valid_i && !dx[11] && (ux < span)
                && !dy[11] && (dy < 12'sd64);
  end

  // Glyph bit lookup for the pixel held in stage 1; MSB is leftmost column
  always_comb begin
    blank = blink_en_i && frame_cnt[5];
    bit_idx = cw'(width_p - 1) - col_q;
    lit = in_q && rom_data_i[bit_idx] && !blank;
  end

  // Shadow registers and frame counter, updated only on frame start
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      origin_x_q <= '0;
      origin_y_q <= '0;
      color_q    <= '0;
      frame_cnt  <= '0;
    end else if (frame_start_i) begin
      origin_x_q <= origin_x_i;
      origin_y_q <= origin_y_i;
      color_q    <= color_i;
      frame_cnt  <= frame_cnt + 6'd1;
    end
  end

  // Stage 1: ROM address, column and qualifiers
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rom_addr_o <= '0;
      col_q      <= '0;
      in_q       <= 1'b0;
      vld_q      <= 1'b0;
    end else begin
      rom_addr_o <= in_region ? {gidx[gw-1:0], dy[5:0]} : '0;
      col_q      <= gcol[cw-1:0];
      in_q       <= in_region;
      vld_q      <= pix_valid_i;
    end
  end

  // Stage 2: lit decision and output colour
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      pix_on_o    <= 1'b0;
      pix_valid_o <= 1'b0;
      rgb_o       <= '0;
    end else begin
      pix_on_o    <= lit;
      pix_valid_o <= vld_q;
      rgb_o       <= lit ? color_q : 12'h000;
    end
  end

endmodule
